id_ex_ctrl_stage: RTL and testbench
===================================

ID_EX_CTRL_STAGE -- requirements
Module: id_ex_ctrl_stage

Interface
REQ-001 Parameter: CNT_W, default 32, width of the stall_count performance counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset=0 clears all state immediately, independent of clk.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_inst  input  32  ID-stage instruction; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
REQ-006 id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_reg_write, id_pc_to_reg, id_is_ecall  input  1 each  decoded control for id_inst.
REQ-007 id_alu_src  input  2  decoded ALU operand select.
REQ-008 ex_flush  input  1  EX-stage redirect (mispredict/jump); kill the instruction entering EX.
REQ-009 ex_valid  output  1  EX stage holds a real instruction.
REQ-010 ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_pc_to_reg, ex_is_ecall  output  1 each  registered control.
REQ-011 ex_alu_src  output  2  registered ALU operand select.
REQ-012 ex_rd  output  5  registered destination register.
REQ-013 stall  output  1  hold PC and IF/ID this cycle (combinational).
REQ-014 stall_count  output  CNT_W  number of stall cycles since reset.

Function
REQ-015 Source usage decoded from id_inst[6:0]: use_rs1 for ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JALR; use_rs2 for ARITHMETIC, STORE, BRANCH; ECALL reads x17 as its single source; all other opcodes use no source.
REQ-016 Internal MEM shadow: mem_load (1 bit) and mem_rd (5 bits), loaded each edge from ex_valid&ex_mem_read and ex_rd; cleared by reset only.
REQ-017 Load-use hazard: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ex_rd matches a used source.
REQ-018 Ecall hazard: id_valid & ECALL opcode & ((ex_valid & ex_reg_write & ex_rd==17) | (mem_load & mem_rd==17)).
REQ-019 stall = (load-use | ecall hazard) & ~ex_flush; flush always wins.
REQ-020 Register update priority per edge: ex_flush -> bubble; else stall -> bubble; else id_valid=0 -> bubble; else capture all id_* controls, ex_rd=id_inst[11:7], ex_valid=1.
REQ-021 Bubble: ex_valid=0, every ex_* control 0, ex_alu_src=00, ex_rd=0.
REQ-022 Latency: captured controls visible on ex_* exactly one cycle after the capturing edge.
REQ-023 x0 never causes a hazard; rd=0 loads never stall.
REQ-024 Load to x17 followed by ECALL: stall exactly 2 cycles (EX load-use, then MEM shadow); non-load write to x17 followed by ECALL: stall exactly 1 cycle.
REQ-025 stall_count increments by 1 on each edge where stall=1; saturates at all-ones, no wrap.
REQ-026 Simultaneous ex_flush and hazard: bubble inserted, stall=0, stall_count unchanged.

Reset
REQ-027 reset=0: ex_valid=0, all ex_* controls 0, ex_alu_src=00, ex_rd=0, mem_load=0, mem_rd=0, stall_count=0; stall evaluates 0 immediately.
REQ-028 Reset asserted mid-stall aborts the stall; first edge after release captures ID normally.

Verification
REQ-029 Reset release, then ADD x5 with id_valid=1 -> next cycle ex_valid=1, ex_reg_write=1, ex_alu_src=00, ex_rd=5, stall=0.
REQ-030 LW x6 then ADD x7,x6,x1 -> stall=1 one cycle, ex_valid=0 bubble, ADD captured next edge, stall_count=1.
REQ-031 LW x17 then ECALL -> stall=1 two consecutive cycles, then ex_is_ecall=1, stall_count=2.
REQ-032 ADDI x17 then ECALL -> stall=1 one cycle; LW x0 then ADD x1,x0,x0 -> no stall.
REQ-033 Load-use hazard with ex_flush=1 same cycle -> stall=0, bubble captured, stall_count unchanged.
REQ-034 CNT_W=4, 20 forced stall cycles -> stall_count holds 4'hF; reset=0 mid-sequence -> all outputs zero asynchronously.

Source files
------------

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use and ECALL (x17) hazard detection.
// Produces a combinational stall and keeps a saturating count of stall cycles.
module id_ex_ctrl_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             id_is_jal,
  input  logic             id_is_jalr,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_pc_to_reg,
  input  logic             id_is_ecall,
  input  logic [1:0]       id_alu_src,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic             ex_is_jal,
  output logic             ex_is_jalr,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_pc_to_reg,
  output logic             ex_is_ecall,
  output logic [1:0]       ex_alu_src,
  output logic [4:0]       ex_rd,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
  localparam logic [4:0] REG_A7       = 5'd17;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] src1;
  logic       use_rs1;
  logic       use_rs2;
  logic       is_ecall_op;
  logic       load_use;
  logic       ecall_hazard;
  logic       capture;
  logic       mem_load;
  logic [4:0] mem_rd;
  logic       unused_inst_bits;

  assign opcode           = id_inst[6:0];
  assign rs1              = id_inst[19:15];
  assign rs2              = id_inst[24:20];
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

  always_comb begin
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    is_ecall_op = 1'b0;
    case (opcode)
      OP_ARITH, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ARITH_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      OP_SYSTEM: begin
        use_rs1     = 1'b1;
        is_ecall_op = 1'b1;
      end
      default: ;
    endcase
  end

  // ECALL's only operand is a7 (x17), so it replaces the rs1 field in the compare
  assign src1 = is_ecall_op ? REG_A7 : rs1;

  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((use_rs1 & (ex_rd == src1)) | (use_rs2 & (ex_rd == rs2)));

  assign ecall_hazard = id_valid & is_ecall_op &
                        ((ex_valid & ex_reg_write & (ex_rd == REG_A7)) |
                         (mem_load & (mem_rd == REG_A7)));

  assign stall   = (load_use | ecall_hazard) & ~ex_flush;
  assign capture = id_valid & ~stall & ~ex_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_is_jal     <= 1'b0;
      ex_is_jalr    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_pc_to_reg  <= 1'b0;
      ex_is_ecall   <= 1'b0;
      ex_alu_src    <= '0;
      ex_rd         <= '0;
      mem_load      <= 1'b0;
      mem_rd        <= '0;
      stall_count   <= '0;
    end else begin
      mem_load      <= ex_valid & ex_mem_read;
      mem_rd        <= ex_rd;
      // flush, stall and empty ID all collapse to the same all-zero bubble
      ex_valid      <= capture;
      ex_is_jal     <= capture & id_is_jal;
      ex_is_jalr    <= capture & id_is_jalr;
      ex_branch     <= capture & id_branch;
      ex_mem_read   <= capture & id_mem_read;
      ex_mem_to_reg <= capture & id_mem_to_reg;
      ex_mem_write  <= capture & id_mem_write;
      ex_reg_write  <= capture & id_reg_write;
      ex_pc_to_reg  <= capture & id_pc_to_reg;
      ex_is_ecall   <= capture & id_is_ecall;
      ex_alu_src    <= capture ? id_alu_src : 2'b00;
      ex_rd         <= capture ? id_inst[11:7] : 5'd0;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage: a default-width and a 4-bit-counter instance
// share stimulus; a reference model queues expected outputs, a monitor compares them.
module tb_id_ex_ctrl_stage;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  // control order: jal jalr branch mem_read mem_to_reg mem_write reg_write pc_to_reg ecall
  localparam logic [8:0] C_LOAD  = 9'b000110100;
  localparam logic [8:0] C_ALU   = 9'b000000100;
  localparam logic [8:0] C_ECALL = 9'b000000001;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic        jal, jalr, branch, mem_read, mem_to_reg, mem_write, reg_write, pc_to_reg, ecall;
    logic [1:0]  alu_src;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic        jal, jalr, branch, mem_read, mem_to_reg, mem_write, reg_write, pc_to_reg, ecall;
    logic [1:0]  alu_src;
    logic [4:0]  rd;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic        stall;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, ex_flush;
  logic [31:0] id_inst;
  logic        id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg;
  logic        id_mem_write, id_reg_write, id_pc_to_reg, id_is_ecall;
  logic [1:0]  id_alu_src;

  logic        a_valid, a_jal, a_jalr, a_branch, a_mr, a_m2r, a_mw, a_rw, a_p2r, a_ecall, a_stall;
  logic [1:0]  a_alu;
  logic [4:0]  a_rd;
  logic [31:0] a_cnt;
  logic        b_valid, b_jal, b_jalr, b_branch, b_mr, b_m2r, b_mw, b_rw, b_p2r, b_ecall, b_stall;
  logic [1:0]  b_alu;
  logic [4:0]  b_rd;
  logic [3:0]  b_cnt;

  id_ex_ctrl_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_pc_to_reg(id_pc_to_reg), .id_is_ecall(id_is_ecall),
    .id_alu_src(id_alu_src), .ex_flush(ex_flush),
    .ex_valid(a_valid), .ex_is_jal(a_jal), .ex_is_jalr(a_jalr), .ex_branch(a_branch),
    .ex_mem_read(a_mr), .ex_mem_to_reg(a_m2r), .ex_mem_write(a_mw), .ex_reg_write(a_rw),
    .ex_pc_to_reg(a_p2r), .ex_is_ecall(a_ecall), .ex_alu_src(a_alu), .ex_rd(a_rd),
    .stall(a_stall), .stall_count(a_cnt)
  );

  id_ex_ctrl_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_pc_to_reg(id_pc_to_reg), .id_is_ecall(id_is_ecall),
    .id_alu_src(id_alu_src), .ex_flush(ex_flush),
    .ex_valid(b_valid), .ex_is_jal(b_jal), .ex_is_jalr(b_jalr), .ex_branch(b_branch),
    .ex_mem_read(b_mr), .ex_mem_to_reg(b_m2r), .ex_mem_write(b_mw), .ex_reg_write(b_rw),
    .ex_pc_to_reg(b_p2r), .ex_is_ecall(b_ecall), .ex_alu_src(b_alu), .ex_rd(b_rd),
    .stall(b_stall), .stall_count(b_cnt)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t expq[$];

  ex_t  m_ex;
  logic m_ml;
  logic [4:0] m_mr;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic last_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic id_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [8:0] ctl, input logic [1:0] alu);
    return id_t'({1'b1, enc(op, rd, rs1, rs2), ctl, alu});
  endfunction

  // Which architectural registers an instruction reads, straight from the opcode class.
  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    case (inst[6:0])
      OP_ARITH, OP_STORE, OP_BRANCH: return (r == inst[19:15]) || (r == inst[24:20]);
      OP_ARITH_IMM, OP_LOAD, OP_JALR: return r == inst[19:15];
      OP_SYSTEM: return r == 5'd17;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus: drive ID, predict this cycle's outputs, then step the model.
  task automatic apply(input id_t id, input bit flush, input bit rst_v);
    exp_t e;
    bit lu, eh, st;
    @(posedge clk);
    #2;
    reset = rst_v;   id_valid = id.valid;   id_inst = id.inst;   ex_flush = flush;
    id_is_jal = id.jal;   id_is_jalr = id.jalr;   id_branch = id.branch;
    id_mem_read = id.mem_read;   id_mem_to_reg = id.mem_to_reg;   id_mem_write = id.mem_write;
    id_reg_write = id.reg_write; id_pc_to_reg = id.pc_to_reg;     id_is_ecall = id.ecall;
    id_alu_src = id.alu_src;
    if (!rst_v) begin
      m_ex = '0;  m_ml = 1'b0;  m_mr = '0;  m_cnt = '0;  m_cnt4 = '0;
    end
    lu = rst_v && id.valid && m_ex.valid && m_ex.mem_read && (m_ex.rd != 0) && reads_reg(id.inst, m_ex.rd);
    eh = rst_v && id.valid && (id.inst[6:0] == OP_SYSTEM) &&
         ((m_ex.valid && m_ex.reg_write && m_ex.rd == 5'd17) || (m_ml && m_mr == 5'd17));
    st = (lu || eh) && !flush;
    e.ex = m_ex;  e.stall = st;  e.cnt = m_cnt;  e.cnt4 = m_cnt4;
    expq.push_back(e);
    if (rst_v) begin
      m_ml = m_ex.valid && m_ex.mem_read;
      m_mr = m_ex.rd;
      if (flush || st || !id.valid) m_ex = '0;
      else m_ex = ex_t'({1'b1, id.jal, id.jalr, id.branch, id.mem_read, id.mem_to_reg, id.mem_write,
                         id.reg_write, id.pc_to_reg, id.ecall, id.alu_src, id.inst[11:7]});
      if (st) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
      end
    end
    last_stall = st;
  endtask

  // Present an instruction, holding it in ID for as long as the model says it stalls.
  task automatic send(input id_t id, input bit rnd_flush);
    int k = 0;
    do begin
      apply(id, rnd_flush ? ($urandom_range(0, 9) == 0) : 1'b0, 1'b1);
      k++;
    end while (last_stall && k < 8);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] pool [5] = '{5'd0, 5'd1, 5'd6, 5'd17, 5'd17};
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return pool[$urandom_range(0, 4)];
  endfunction

  function automatic id_t rand_id();
    logic [6:0] ops [9] = '{OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                            OP_JALR, OP_JAL, OP_LUI, OP_SYSTEM};
    id_t r;
    r = mk(ops[$urandom_range(0, 8)], pick_reg(), pick_reg(), pick_reg(), 9'($urandom), 2'($urandom));
    r.valid = ($urandom_range(0, 9) != 0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("ex_regs", 64'({a_valid, a_jal, a_jalr, a_branch, a_mr, a_m2r, a_mw, a_rw, a_p2r,
                          a_ecall, a_alu, a_rd}), 64'(e.ex));
      chk("stall", 64'(a_stall), 64'(e.stall));
      chk("stall_count", 64'(a_cnt), 64'(e.cnt));
      chk("ex_regs_w4", 64'({b_valid, b_jal, b_jalr, b_branch, b_mr, b_m2r, b_mw, b_rw, b_p2r,
                             b_ecall, b_alu, b_rd}), 64'(e.ex));
      chk("stall_w4", 64'(b_stall), 64'(e.stall));
      chk("stall_count_w4", 64'(b_cnt), 64'(e.cnt4));
    end
  end

  initial begin
    id_t nop;
    nop = '0;
    reset = 1'b0;  id_valid = 1'b0;  id_inst = '0;  ex_flush = 1'b0;
    id_is_jal = 0; id_is_jalr = 0; id_branch = 0; id_mem_read = 0; id_mem_to_reg = 0;
    id_mem_write = 0; id_reg_write = 0; id_pc_to_reg = 0; id_is_ecall = 0; id_alu_src = '0;
    m_ex = '0;  m_ml = 1'b0;  m_mr = '0;  m_cnt = '0;  m_cnt4 = '0;  last_stall = 1'b0;

    apply(nop, 1'b0, 1'b0);
    apply(nop, 1'b0, 1'b0);
    send(mk(OP_ARITH, 5'd5, 5'd1, 5'd2, C_ALU, 2'b00), 1'b0);
    send(nop, 1'b0);
    // load-use on x6
    send(mk(OP_LOAD, 5'd6, 5'd1, 5'd0, C_LOAD, 2'b01), 1'b0);
    send(mk(OP_ARITH, 5'd7, 5'd6, 5'd1, C_ALU, 2'b00), 1'b0);
    // load to x17 then ECALL, then ALU write to x17 then ECALL
    send(mk(OP_LOAD, 5'd17, 5'd2, 5'd0, C_LOAD, 2'b01), 1'b0);
    send(mk(OP_SYSTEM, 5'd0, 5'd0, 5'd0, C_ECALL, 2'b00), 1'b0);
    send(mk(OP_ARITH_IMM, 5'd17, 5'd0, 5'd0, C_ALU, 2'b01), 1'b0);
    send(mk(OP_SYSTEM, 5'd0, 5'd0, 5'd0, C_ECALL, 2'b00), 1'b0);
    // x0 never hazards
    send(mk(OP_LOAD, 5'd0, 5'd3, 5'd0, C_LOAD, 2'b01), 1'b0);
    send(mk(OP_ARITH, 5'd1, 5'd0, 5'd0, C_ALU, 2'b00), 1'b0);
    // flush coinciding with a load-use hazard
    send(mk(OP_LOAD, 5'd6, 5'd1, 5'd0, C_LOAD, 2'b01), 1'b0);
    apply(mk(OP_ARITH, 5'd7, 5'd6, 5'd1, C_ALU, 2'b00), 1'b1, 1'b1);
    send(mk(OP_ARITH, 5'd7, 5'd6, 5'd1, C_ALU, 2'b00), 1'b0);
    // drive the 4-bit counter well past saturation
    for (int i = 0; i < 10; i++) begin
      send(mk(OP_LOAD, 5'd17, 5'd2, 5'd0, C_LOAD, 2'b01), 1'b0);
      send(mk(OP_SYSTEM, 5'd0, 5'd0, 5'd0, C_ECALL, 2'b00), 1'b0);
    end
    // reset asserted in the middle of a two-cycle ECALL stall
    send(mk(OP_LOAD, 5'd17, 5'd2, 5'd0, C_LOAD, 2'b01), 1'b0);
    apply(mk(OP_SYSTEM, 5'd0, 5'd0, 5'd0, C_ECALL, 2'b00), 1'b0, 1'b1);
    apply(mk(OP_SYSTEM, 5'd0, 5'd0, 5'd0, C_ECALL, 2'b00), 1'b0, 1'b0);
    send(mk(OP_SYSTEM, 5'd0, 5'd0, 5'd0, C_ECALL, 2'b00), 1'b0);
    send(nop, 1'b0);

    for (int n = 0; n < 600; n++) send(rand_id(), 1'b1);

    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
    n_cmp++;
    if (expq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
